// File: rtl/std_gray_pkg.sv
// Shared helpers for the Gray-decode arbiter: round-robin pick and index-width sizing.
package std_gray_pkg;

  // Widest requester vector rr_pick can arbitrate.
  localparam int MAXN = 32;

  function automatic int idw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot grant of the first set bit at or above ptr, wrapping at n.
  function automatic logic [MAXN-1:0] rr_pick(input logic [MAXN-1:0] valid,
                                              input int ptr, input int n);
    logic [MAXN-1:0] gnt;
    logic            found;
    int              idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAXN; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && valid[idx]) begin
          gnt[idx] = 1'b1;
          found    = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/std_gray_decoder.sv
// Combinational Gray-to-binary decoder: o_bin[j] = XOR of i_gray[WIDTH-1:j].
module std_gray_decoder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  logic [WIDTH-1:0] acc;

  // Log-depth suffix XOR: each pass doubles the span folded into every bit.
  always_comb begin
    acc = i_gray;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      acc = acc ^ (acc >> s);
    end
    o_bin = acc;
  end

endmodule

// File: rtl/std_gray_decode_arbiter.sv
// Round-robin arbiter sharing one Gray decoder among N requesters,
// with a single registered valid/ready result stage.
module std_gray_decode_arbiter
  import std_gray_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  localparam int IDW   = idw_of(N)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N-1:0]     i_valid,
  output logic [N-1:0]     o_ready,
  input  logic [WIDTH-1:0] i_gray [N],
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_bin,
  output logic [IDW-1:0]   o_id
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             load;
  logic             hs;
  logic [N-1:0]     gnt;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] gray_sel;
  logic [WIDTH-1:0] dec_bin;

  assign load = !valid_q || i_ready;
  assign gnt  = N'(rr_pick(MAXN'(i_valid), int'(ptr_q), N));

  // Reset gating keeps o_ready quiet while the output register is held clear.
  assign o_ready = (load && i_rst_n) ? gnt : '0;
  assign hs      = |(i_valid & o_ready);

  always_comb begin
    gray_sel = '0;
    gnt_id   = '0;
    for (int k = 0; k < N; k++) begin
      gray_sel = gray_sel | (i_gray[k] & {WIDTH{gnt[k]}});
      if (gnt[k]) gnt_id = IDW'(k);
    end
  end

  std_gray_decoder #(.WIDTH(WIDTH)) u_dec (
    .i_gray (gray_sel),
    .o_bin  (dec_bin)
  );

  always_comb begin
    valid_d = valid_q;
    bin_d   = bin_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    if (hs) begin
      valid_d = 1'b1;
      bin_d   = dec_bin;
      id_d    = gnt_id;
      ptr_d   = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  // Output register stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      bin_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      bin_q   <= bin_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_valid = valid_q;
  assign o_bin   = bin_q;
  assign o_id    = id_q;

endmodule

// File: tb/tb_std_gray_decode_arbiter.sv
// Scoreboard bench for std_gray_decode_arbiter (WIDTH=4, N=4) with a queue-based reference model.
module tb_std_gray_decode_arbiter;

  localparam int W   = 4;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NR-1:0]  i_valid;
  logic [NR-1:0]  o_ready;
  logic [W-1:0]   i_gray [NR];
  logic           o_valid;
  logic           i_ready;
  logic [W-1:0]   o_bin;
  logic [IDW-1:0] o_id;

  always #5 clk = ~clk;

  std_gray_decode_arbiter #(.WIDTH(W), .N(NR)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_gray  (i_gray),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_bin   (o_bin),
    .o_id    (o_id)
  );

  typedef struct {
    int id;
    int bin;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            errors = 0;
  int            m_ptr;
  bit            m_valid;
  bit            cur_valid;
  bit            mon_en;
  logic [W-1:0]  gset [NR];
  logic [NR-1:0] last_acc;
  logic [NR-1:0] v_prev;

  // Binary value whose Gray encoding is g, found by search.
  function automatic int ref_decode(input int g);
    for (int v = 0; v < (1 << W); v++)
      if ((v ^ (v >> 1)) == g) return v;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model predicts grant, pointer and result.
  task automatic step(input logic [NR-1:0] v, input logic r);
    logic [NR-1:0] exp_rdy;
    int            k;
    bit            ld;
    @(posedge clk);
    #1;
    cur_valid = m_valid;
    i_valid   = v;
    i_ready   = r;
    i_gray    = gset;
    #1;
    exp_rdy = '0;
    k       = -1;
    ld      = !m_valid || r;
    if (ld) begin
      for (int i = 0; i < NR; i++) begin
        int c;
        c = (m_ptr + i) % NR;
        if (k < 0 && v[c]) k = c;
      end
    end
    if (k >= 0) exp_rdy[k] = 1'b1;
    check("o_ready", int'(o_ready), int'(exp_rdy));
    last_acc = exp_rdy;
    if (k >= 0) begin
      q.push_back('{k, ref_decode(int'(gset[k]))});
      m_ptr   = (k + 1) % NR;
      m_valid = 1'b1;
    end else if (ld) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_o_valid", int'(o_valid), 0);
    check("rst_o_bin", int'(o_bin), 0);
    check("rst_o_id", int'(o_id), 0);
    check("rst_o_ready", int'(o_ready), 0);
    q.delete();
    m_valid   = 1'b0;
    m_ptr     = 0;
    cur_valid = 1'b0;
    i_valid   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare the presented result against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("o_valid", int'(o_valid), int'(cur_valid));
        if (o_valid) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: o_valid=1 id=%0d bin=%0d with nothing expected", o_id, o_bin);
          end else begin
            check("o_id", int'(o_id), q[0].id);
            check("o_bin", int'(o_bin), q[0].bin);
            if (i_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    i_valid   = '1;
    i_ready   = 1'b0;
    mon_en    = 1'b0;
    m_ptr     = 0;
    m_valid   = 1'b0;
    cur_valid = 1'b0;
    last_acc  = '0;
    v_prev    = '0;
    for (int i = 0; i < NR; i++) gset[i] = '0;
    i_gray = gset;

    repeat (2) @(posedge clk);
    #2;
    check("reset_o_valid", int'(o_valid), 0);
    check("reset_o_bin", int'(o_bin), 0);
    check("reset_o_id", int'(o_id), 0);
    check("reset_o_ready", int'(o_ready), 0);
    i_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_o_valid", int'(o_valid), 0);
    mon_en = 1'b1;

    // Single request from requester 1
    gset[1] = 4'b0110;
    step(4'b0010, 1'b1);
    step(4'b0000, 1'b1);
    check("single_bin", int'(o_bin), 4);
    check("single_id", int'(o_id), 1);

    // Round robin from a fresh reset
    async_reset();
    gset[0] = 4'b0001;
    gset[1] = 4'b0011;
    gset[2] = 4'b1000;
    gset[3] = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step((i < 5) ? 4'b1111 : 4'b0000, 1'b1);
      if (i > 0) begin
        check("rr_id", int'(o_id), (i - 1) % 4);
        if ((i - 1) % 4 == 2) check("rr_bin2", int'(o_bin), 15);
      end
    end

    // Backpressure then release with same-cycle reload
    step(4'b1111, 1'b0);
    repeat (3) step(4'b1111, 1'b0);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);

    // Sparse wrap from ptr=3, then idle keeps the pointer
    step(4'b0001, 1'b1);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);

    // Reset while a result is held under backpressure
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    async_reset();
    step(4'b1111, 1'b1);
    step(4'b0000, 1'b1);
    check("after_reset_id", int'(o_id), 0);

    // Randomized traffic honouring the hold-until-accepted rule
    v_prev = '0;
    for (int c = 0; c < 400; c++) begin
      logic [NR-1:0] v;
      for (int k = 0; k < NR; k++) begin
        if (!v_prev[k] || last_acc[k]) begin
          v[k]    = ($urandom_range(0, 2) != 0);
          gset[k] = W'($urandom);
        end else begin
          v[k] = 1'b1;
        end
      end
      step(v, ($urandom_range(0, 3) != 0));
      v_prev = v;
    end

    step(4'b0000, 1'b1);
    step(4'b0000, 1'b1);
    check("queue_drain", q.size(), 0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
